// File: rtl/if_redirect_ctrl_pkg.sv
// rtl/if_redirect_ctrl_pkg.sv - shared types and helpers for the PC redirect controller
package if_redirect_ctrl_pkg;

    localparam int MXLEN = 32;

    typedef enum logic [1:0] {
        SRC_IF0 = 2'd0,
        SRC_IF1 = 2'd1,
        SRC_IF2 = 2'd2,
        SRC_EXU = 2'd3
    } redir_src_e;

    typedef enum logic [1:0] {
        RS_IDLE  = 2'd0,
        RS_HOLD  = 2'd1,
        RS_DRAIN = 2'd2
    } redir_state_e;

    typedef struct packed {
        logic [MXLEN-1:0] npc;
        redir_src_e       src;
    } redir_req_t;

    // Stages younger than the redirecting stage are squashed: bit0=if0, bit1=if1, bit2=if2.
    function automatic logic [2:0] flush_mask(input redir_src_e src);
        logic [2:0] m;
        m = 3'b000;
        case (src)
            SRC_IF1: m = 3'b001;
            SRC_IF2: m = 3'b011;
            SRC_EXU: m = 3'b111;
            default: m = 3'b000;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/if_redirect_ctrl_arb.sv
// rtl/if_redirect_ctrl_arb.sv - fixed-priority npc/valid select across the four redirect sources
module if_redirect_ctrl_arb #(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] i_if0_npc,
    input  logic            i_if0_valid,
    input  logic [XLEN-1:0] i_if1_npc,
    input  logic            i_if1_valid,
    input  logic [XLEN-1:0] i_if2_npc,
    input  logic            i_if2_valid,
    input  logic [XLEN-1:0] i_exu_npc,
    input  logic            i_exu_valid,
    output logic            o_valid,
    output logic [XLEN-1:0] o_npc
);

    // Oldest stage wins: exu > if2 > if1 > if0.
    always_comb begin
        o_valid = i_exu_valid | i_if2_valid | i_if1_valid | i_if0_valid;
        o_npc   = '0;
        if (i_exu_valid)      o_npc = i_exu_npc;
        else if (i_if2_valid) o_npc = i_if2_npc;
        else if (i_if1_valid) o_npc = i_if1_npc;
        else if (i_if0_valid) o_npc = i_if0_npc;
    end

endmodule

// File: rtl/if_redirect_ctrl.sv
// rtl/if_redirect_ctrl.sv - redirect sequencing, hold, drain window, flush pulses and fetch epoch
module if_redirect_ctrl
    import if_redirect_ctrl_pkg::*;
#(
    parameter int XLEN         = MXLEN,
    parameter int EPOCH_W      = 2,
    parameter int DRAIN_CYCLES = 3
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic [XLEN-1:0]    i_if0_pcRedirect_npc,
    input  logic [XLEN-1:0]    i_if1_pcRedirect_npc,
    input  logic [XLEN-1:0]    i_if2_pcRedirect_npc,
    input  logic [XLEN-1:0]    i_exu_pcRedirect_npc,
    input  logic               i_if0_pcRedirect_npc_valid,
    input  logic               i_if1_pcRedirect_npc_valid,
    input  logic               i_if2_pcRedirect_npc_valid,
    input  logic               i_exu_pcRedirect_npc_valid,
    input  logic               i_npcGen_ready,
    output logic               o_redir_valid,
    output logic [XLEN-1:0]    o_redir_npc,
    output logic [1:0]         o_redir_src,
    output logic               o_flush_if0,
    output logic               o_flush_if1,
    output logic               o_flush_if2,
    output logic [EPOCH_W-1:0] o_epoch
);

    localparam int                CNT_W      = (DRAIN_CYCLES < 1) ? 1 : $clog2(DRAIN_CYCLES + 1);
    localparam logic [CNT_W-1:0]  DRAIN_LOAD = CNT_W'(DRAIN_CYCLES);

    logic            w_valid;
    logic [XLEN-1:0] w_npc;
    redir_src_e      w_src;
    logic            accept;
    logic            capture;

    redir_state_e       state_q, state_d;
    logic [XLEN-1:0]    pend_npc_q, pend_npc_d;
    redir_src_e         pend_src_q, pend_src_d;
    logic [2:0]         flush_q, flush_d;
    logic [EPOCH_W-1:0] epoch_q, epoch_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    if_redirect_ctrl_arb #(.XLEN(XLEN)) u_arb (
        .i_if0_npc   (i_if0_pcRedirect_npc),
        .i_if0_valid (i_if0_pcRedirect_npc_valid),
        .i_if1_npc   (i_if1_pcRedirect_npc),
        .i_if1_valid (i_if1_pcRedirect_npc_valid),
        .i_if2_npc   (i_if2_pcRedirect_npc),
        .i_if2_valid (i_if2_pcRedirect_npc_valid),
        .i_exu_npc   (i_exu_pcRedirect_npc),
        .i_exu_valid (i_exu_pcRedirect_npc_valid),
        .o_valid     (w_valid),
        .o_npc       (w_npc)
    );

    // 4:2 priority encoder giving the winning source id.
    always_comb begin
        w_src = SRC_IF0;
        if (i_exu_pcRedirect_npc_valid)      w_src = SRC_EXU;
        else if (i_if2_pcRedirect_npc_valid) w_src = SRC_IF2;
        else if (i_if1_pcRedirect_npc_valid) w_src = SRC_IF1;
    end

    // Decide whether this cycle's winner is taken; an accepted exu entry shadows younger-stage requests.
    always_comb begin
        accept  = (state_q == RS_HOLD) && i_npcGen_ready;
        capture = 1'b0;
        case (state_q)
            RS_IDLE: capture = w_valid;
            RS_HOLD: begin
                if (accept && (pend_src_q == SRC_EXU))
                    capture = w_valid && (w_src == SRC_EXU);
                else
                    capture = w_valid && (accept || (w_src >= pend_src_q));
            end
            RS_DRAIN: capture = w_valid && (w_src == SRC_EXU);
            default:  capture = 1'b0;
        endcase
    end

    // Next-state, pending entry, flush, epoch and drain counter.
    always_comb begin
        state_d    = state_q;
        pend_npc_d = pend_npc_q;
        pend_src_d = pend_src_q;
        flush_d    = 3'b000;
        epoch_d    = epoch_q;
        cnt_d      = cnt_q;
        if (capture) begin
            state_d    = RS_HOLD;
            pend_npc_d = w_npc;
            pend_src_d = w_src;
            flush_d    = flush_mask(w_src);
            cnt_d      = '0;
            if (w_src == SRC_EXU) epoch_d = epoch_q + EPOCH_W'(1);
        end else begin
            case (state_q)
                RS_HOLD: begin
                    if (accept) begin
                        if ((pend_src_q == SRC_EXU) && (DRAIN_CYCLES > 0)) begin
                            state_d = RS_DRAIN;
                            cnt_d   = DRAIN_LOAD;
                        end else begin
                            state_d = RS_IDLE;
                        end
                    end
                end
                RS_DRAIN: begin
                    cnt_d = cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) state_d = RS_IDLE;
                end
                default: ;
            endcase
        end
    end

    // State and output registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= RS_IDLE;
            pend_npc_q <= '0;
            pend_src_q <= SRC_IF0;
            flush_q    <= 3'b000;
            epoch_q    <= '0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            pend_npc_q <= pend_npc_d;
            pend_src_q <= pend_src_d;
            flush_q    <= flush_d;
            epoch_q    <= epoch_d;
            cnt_q      <= cnt_d;
        end
    end

    assign o_redir_valid = (state_q == RS_HOLD);
    assign o_redir_npc   = pend_npc_q;
    assign o_redir_src   = pend_src_q;
    assign o_flush_if0   = flush_q[0];
    assign o_flush_if1   = flush_q[1];
    assign o_flush_if2   = flush_q[2];
    assign o_epoch       = epoch_q;

endmodule

// File: tb/tb_if_redirect_ctrl.sv
// tb/tb_if_redirect_ctrl.sv - self-checking bench for if_redirect_ctrl
module tb_if_redirect_ctrl;

    localparam int XLEN  = 32;
    localparam int EW    = 2;
    localparam int DRAIN = 3;

    logic            clk;
    logic            rst_n;
    logic [3:0]      req_v;
    logic [XLEN-1:0] req_npc [4];
    logic            ready;

    logic            o_redir_valid;
    logic [XLEN-1:0] o_redir_npc;
    logic [1:0]      o_redir_src;
    logic            o_flush_if0, o_flush_if1, o_flush_if2;
    logic [EW-1:0]   o_epoch;

    int n_chk  = 0;
    int n_pass = 0;
    bit chk_en = 0;

    // Reference model state
    bit          m_pend;
    int          m_npc;
    int          m_src;
    int          m_drain;
    int          m_epoch;
    logic [2:0]  m_flush;

    if_redirect_ctrl #(.XLEN(XLEN), .EPOCH_W(EW), .DRAIN_CYCLES(DRAIN)) dut (
        .i_clk                      (clk),
        .i_rst_n                    (rst_n),
        .i_if0_pcRedirect_npc       (req_npc[0]),
        .i_if1_pcRedirect_npc       (req_npc[1]),
        .i_if2_pcRedirect_npc       (req_npc[2]),
        .i_exu_pcRedirect_npc       (req_npc[3]),
        .i_if0_pcRedirect_npc_valid (req_v[0]),
        .i_if1_pcRedirect_npc_valid (req_v[1]),
        .i_if2_pcRedirect_npc_valid (req_v[2]),
        .i_exu_pcRedirect_npc_valid (req_v[3]),
        .i_npcGen_ready             (ready),
        .o_redir_valid              (o_redir_valid),
        .o_redir_npc                (o_redir_npc),
        .o_redir_src                (o_redir_src),
        .o_flush_if0                (o_flush_if0),
        .o_flush_if1                (o_flush_if1),
        .o_flush_if2                (o_flush_if2),
        .o_epoch                    (o_epoch)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        else n_pass++;
    endtask

    task automatic model_reset();
        m_pend = 0; m_npc = 0; m_src = 0; m_drain = 0; m_epoch = 0; m_flush = 3'b000;
    endtask

    // One clock of the redirect rules, evaluated from the inputs present at the edge.
    task automatic model_step();
        int  w;
        bit  acc, take;
        w = -1;
        for (int s = 3; s >= 0; s--) if (req_v[s] && w < 0) w = s;
        acc  = m_pend && ready;
        take = 0;
        if (w >= 0) begin
            if (m_drain > 0)               take = (w == 3);
            else if (!m_pend)              take = 1;
            else if (acc && m_src == 3)    take = (w == 3);
            else                           take = acc || (w >= m_src);
        end
        m_flush = 3'b000;
        if (take) begin
            m_flush = {w == 3, w >= 2, w >= 1};
            m_pend  = 1;
            m_npc   = int'(req_npc[w]);
            if (w == 3) m_epoch = (m_epoch + 1) % (1 << EW);
            m_src   = w;
            m_drain = 0;
        end else if (acc) begin
            m_pend  = 0;
            m_drain = (m_src == 3) ? DRAIN : 0;
        end else if (m_drain > 0) begin
            m_drain = m_drain - 1;
        end
    endtask

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("valid", 32'(o_redir_valid), 32'(m_pend));
            chk("flush", 32'({o_flush_if2, o_flush_if1, o_flush_if0}), 32'(m_flush));
            chk("epoch", 32'(o_epoch), 32'(m_epoch));
            if (m_pend) begin
                chk("npc", o_redir_npc, 32'(m_npc));
                chk("src", 32'(o_redir_src), 32'(m_src));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic req(input int s, input logic [31:0] npc);
        req_v[s]   = 1'b1;
        req_npc[s] = npc;
    endtask

    task automatic clr();
        req_v = 4'b0000;
    endtask

    initial begin
        rst_n = 1'b0;
        ready = 1'b0;
        req_v = 4'b0000;
        for (int i = 0; i < 4; i++) req_npc[i] = '0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", 32'(o_redir_valid), 32'd0);
        chk("rst_npc",   o_redir_npc, 32'd0);
        chk("rst_src",   32'(o_redir_src), 32'd0);
        chk("rst_flush", 32'({o_flush_if2, o_flush_if1, o_flush_if0}), 32'd0);
        chk("rst_epoch", 32'(o_epoch), 32'd0);
        rst_n  = 1'b1;
        chk_en = 1;
        step();

        // 1: single if1 redirect accepted immediately
        ready = 1'b1; req(1, 32'h1000);
        step(); clr();
        chk("t1_valid", 32'(o_redir_valid), 32'd1);
        chk("t1_npc",   o_redir_npc, 32'h1000);
        chk("t1_flush", 32'({o_flush_if2, o_flush_if1, o_flush_if0}), 32'b001);
        step();
        chk("t1_idle",  32'(o_redir_valid), 32'd0);
        chk("t1_epoch", 32'(o_epoch), 32'd0);

        // 2: if0 held, replaced by higher-priority if2, then accepted
        ready = 1'b0; req(0, 32'h2000);
        step(); clr();
        chk("t2_npc0", o_redir_npc, 32'h2000);
        step();
        req(2, 32'h3000);
        step(); clr();
        chk("t2_npc1",   o_redir_npc, 32'h3000);
        chk("t2_flush",  32'({o_flush_if2, o_flush_if1, o_flush_if0}), 32'b011);
        ready = 1'b1;
        step();
        chk("t2_acc", 32'(o_redir_valid), 32'd0);

        // 3: pending exu is not displaced by if2
        ready = 1'b0; req(3, 32'h4000);
        step(); clr();
        chk("t3_epoch", 32'(o_epoch), 32'd1);
        req(2, 32'h5000);
        step(); clr();
        chk("t3_npc",   o_redir_npc, 32'h4000);
        chk("t3_flush", 32'({o_flush_if2, o_flush_if1, o_flush_if0}), 32'b000);
        ready = 1'b1;
        step();
        repeat (3) step();

        // 4: drain window drops if1 for three cycles
        req(3, 32'h8000);
        step(); clr();
        chk("t4_npc", o_redir_npc, 32'h8000);
        step();
        for (int i = 0; i < 3; i++) begin
            req(1, 32'h6000 + 32'(i));
            step(); clr();
            chk("t4_drop", 32'(o_redir_valid), 32'd0);
        end
        req(1, 32'h7000);
        step(); clr();
        chk("t4_cap", o_redir_npc, 32'h7000);
        step();

        // 5: exu during drain is captured; epoch wraps 3->0
        req(3, 32'h8800);
        step(); clr();
        step();
        req(3, 32'h9000);
        step(); clr();
        chk("t5_npc",   o_redir_npc, 32'h9000);
        chk("t5_flush", 32'({o_flush_if2, o_flush_if1, o_flush_if0}), 32'b111);
        chk("t5_epoch", 32'(o_epoch), 32'd0);
        ready = 1'b0; req(3, 32'hA000);
        step(); clr();
        chk("t5_repl", 32'(o_epoch), 32'd1);

        // 6: all four sources at once, then async reset mid-hold
        req(0, 32'h100); req(1, 32'h200); req(2, 32'h300); req(3, 32'hB000);
        step(); clr();
        chk("t6_src",   32'(o_redir_src), 32'd3);
        chk("t6_npc",   o_redir_npc, 32'hB000);
        chk("t6_flush", 32'({o_flush_if2, o_flush_if1, o_flush_if0}), 32'b111);
        chk_en = 0;
        #1 rst_n = 1'b0;
        #1;
        chk("t6_rvalid", 32'(o_redir_valid), 32'd0);
        chk("t6_rnpc",   o_redir_npc, 32'd0);
        chk("t6_repoch", 32'(o_epoch), 32'd0);
        chk("t6_rflush", 32'({o_flush_if2, o_flush_if1, o_flush_if0}), 32'd0);
        model_reset();
        @(posedge clk);
        #2 rst_n = 1'b1;
        chk_en = 1;
        ready = 1'b1; req(2, 32'hC000);
        step(); clr();
        chk("t6_after", o_redir_npc, 32'hC000);
        step();
        step();
        chk_en = 0;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/if_redirect_ctrl.md
Name: if_redirect_ctrl

Overview:
- Sequences PC redirects from the four redirect sources into the PC register / npcGen stage.
- Arbitrates by fixed priority: exu > if2 > if1 > if0.
- Holds a pending redirect until npcGen accepts it, emits registered per-stage flush pulses, and maintains a fetch epoch.
- After an exu redirect, drops wrong-path IF-stage redirects for a fixed drain window.

Parameters:
- XLEN, `MXLEN, width of PC values.
- EPOCH_W, 2, width of the fetch epoch counter.
- DRAIN_CYCLES, 3, cycles after an accepted exu redirect during which IF-stage requests are dropped. 0 means no drain.

Ports:
- i_clk  in  1  clock, rising edge.
- i_rst_n  in  1  reset, asynchronous, active-low.
- i_if0_pcRedirect_npc / i_if1_pcRedirect_npc / i_if2_pcRedirect_npc / i_exu_pcRedirect_npc  in  XLEN each  redirect target per source.
- i_if0_pcRedirect_npc_valid / i_if1_… / i_if2_… / i_exu_…  in  1 each  redirect request per source.
- i_npcGen_ready  in  1  npcGen accepts o_redir_npc this cycle.
- o_redir_valid  out  1  redirect presented to npcGen.
- o_redir_npc  out  XLEN  redirect target.
- o_redir_src  out  2  source, redir_src_e.
- o_flush_if0 / o_flush_if1 / o_flush_if2  out  1 each  one-cycle squash pulse per fetch stage.
- o_epoch  out  EPOCH_W  current fetch epoch.

Behaviour:
- Reset (asynchronous, any time including mid-HOLD or mid-DRAIN):
  - state=IDLE, o_redir_valid=0, o_redir_npc=0, o_redir_src=SRC_IF0.
  - All flushes=0, o_epoch=0, drain counter=0.
  - Pending request is discarded.
- Request selection per cycle: highest-priority valid source (W = winner, numeric src value = priority). Lower-priority simultaneous requests are discarded, not queued.
- Capture rules: W is captured into the pending register (npc, src), with all outputs registered, visible next cycle, when:
  - IDLE: any W.
  - HOLD: W is captured if src(W) >= src(pending), or if the pending entry is being accepted this cycle. Otherwise W is dropped.
  - DRAIN: only W=EXU is captured. IF-source requests are dropped.
- Exception to the HOLD rule, acceptance cycle of an exu entry: a non-exu W arriving in the cycle an exu entry is accepted is dropped.
- States:
  - IDLE: o_redir_valid=0. A capture goes to HOLD.
  - HOLD: o_redir_valid=1; npc/src are stable unless replaced by a capture. On i_npcGen_ready=1 the entry is accepted, then:
    - if a new W is captured in the same cycle: stay HOLD with the new entry;
    - else if the accepted src=EXU and DRAIN_CYCLES>0: go to DRAIN and load the counter with DRAIN_CYCLES;
    - else: go to IDLE.
  - DRAIN: counter decrements each cycle; at 1 go to IDLE. A captured exu request goes to HOLD and clears the counter.
- Latency: request in cycle N → o_redir_valid in N+1 → earliest acceptance in N+1. A back-to-back accept costs one cycle per redirect.
- Flush: on each capture, a one-cycle pulse in N+1:
  - EXU: if0, if1, if2.
  - IF2: if0, if1.
  - IF1: if0.
  - IF0: none.
  - Dropped requests produce no flush. Consecutive captures give consecutive pulses.
- Epoch: +1 (mod 2^EPOCH_W, wraps) on each exu capture, visible N+1. A replacement of a pending exu by a newer exu increments again.
- o_redir_npc is taken as-is; no alignment or width change.

Decomposition:
- Shared package risXv_pkg (or the existing macro package):
  - typedef enum logic [1:0] redir_src_e {SRC_IF0=0, SRC_IF1=1, SRC_IF2=2, SRC_EXU=3};
  - typedef enum logic [1:0] redir_state_e {RS_IDLE, RS_HOLD, RS_DRAIN};
  - typedef struct packed {logic [`MXLEN-1:0] npc; redir_src_e src;} redir_req_t.
- Sub-module: instantiate the existing pcRedirect arbiter for npc/valid selection. Add a local 4:2 priority encoder for src. The FSM, drain counter, epoch and flush registers live in if_redirect_ctrl.

Test Plan:
1. Reset, then if1 valid npc=0x1000 in cycle 5 with ready=1 → cycle 6: o_redir_valid=1, npc=0x1000, src=1, o_flush_if0=1 only. Cycle 7: IDLE, valid=0, epoch=0.
2. ready=0, if0 npc=0x2000 at cycle 5, if2 npc=0x3000 at cycle 7, ready=1 at cycle 9 → npc=0x2000 for cycles 6-7, 0x3000 from cycle 8. Accepted at 9. Flush if0 at 6; if0+if1 at 8.
3. ready=0, pending exu npc=0x4000; if2 request npc=0x5000 → dropped: npc stays 0x4000 and no flush. Epoch=1 after the exu capture.
4. exu npc=0x8000 accepted immediately (DRAIN_CYCLES=3), then if1 valid in each of the next 3 cycles → all dropped, valid=0. An if1 in the 4th cycle (IDLE) is captured.
5. In DRAIN, exu npc=0x9000 → HOLD next cycle, all three flushes pulse, epoch=2. Four exu captures with EPOCH_W=2 → epoch wraps 3→0.
6. All four sources valid in the same cycle → src=3, exu npc selected, single flush of all stages. Assert i_rst_n=0 asynchronously mid-HOLD → outputs zero immediately, without waiting for a clock edge.
